cordic_job_arbiter: RTL
=======================

Name: cordic_job_arbiter

Overview:
Shares one iterative CORDIC engine between two requesters (e.g. CPU register front-end and a DMA/stream client). Accepts jobs (mode, direction, fixed-point shift, A, B) over valid/ready and arbitrates round-robin. Sequences the engine's one-cycle start pulse, holds operands stable, waits for done, and returns the results to the granted requester with a response handshake. Sits between the peripheral register file and the CORDIC core.

Parameters:
FIXED_WIDTH, 16, operand/result width.
SHIFT_W, 5, width of the fixed-point one-position field (clog2(FIXED_WIDTH)+1).
TIMEOUT_CYCLES, 64, watchdog limit in WAIT; only used with the optional feature.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
req_valid  in  2  per-requester job valid; bit i = requester i.
req_ready  out  2  per-requester accept; at most one bit high.
req_mode  in  4  {mode1[1:0], mode0[1:0]}; 0 circular, 1 linear, 2 hyperbolic.
req_is_rotating  in  2  per-requester rotation(1)/vectoring(0).
req_shift  in  2*SHIFT_W  per-requester position of 1.0; slice i = [i*SHIFT_W +: SHIFT_W].
req_a, req_b  in  2*FIXED_WIDTH each  per-requester operands, sliced likewise.
rsp_valid  out  2  per-requester result valid.
rsp_ready  in  2  per-requester result accept.
rsp_out1, rsp_out2  out  FIXED_WIDTH  shared result bus, valid for the requester whose rsp_valid is high.
rsp_err  out  1  result is a timeout (optional feature only, else 0).
core_start  out  1  one-cycle start pulse to the engine.
core_mode  out  2; core_is_rotating  out  1; core_shift  out  SHIFT_W; core_a, core_b  out  FIXED_WIDTH each.  Registered job fields to the engine.
core_out1, core_out2  in  FIXED_WIDTH  engine results.
core_done  in  1  engine one-cycle completion pulse.
busy  out  1  state != IDLE.
spurious_done  out  1  sticky: core_done seen outside WAIT.

Behaviour:
- Reset (rst=1 at clk edge): state IDLE. req_ready=0 is derived, so it is 0 only while rst is held; rsp_valid=0, core_start=0, core_* fields=0, rsp_out1/out2=0, rsp_err=0, spurious_done=0. The RR pointer last_grant resets to 1, so requester 0 wins first. Reset mid-job abandons the job, and no response is issued. A core_done arriving after reset is treated as spurious.
- Grant (combinational, IDLE only): if exactly one req_valid is set, grant it. If both are set, grant the one not equal to last_grant. req_ready[g] = (state==IDLE) & req_valid[g].
- States:
  - IDLE: on req_valid[g] & req_ready[g], latch the job fields into the core_* registers, record owner=g, set last_grant=g, and go to ISSUE.
  - ISSUE: core_start=1 for exactly this cycle, then go to WAIT.
  - WAIT: on core_done, capture core_out1/out2 into rsp_out1/out2 and go to RESP.
  - RESP: rsp_valid[owner]=1, with the result held stable. On rsp_ready[owner], go to IDLE.
- Job latency: accept at cycle N, core_start at N+1, core_done at N+1+K (engine latency K≥1), rsp_valid from N+2+K.
- Earliest next accept is the cycle after the response handshake.
- core_* fields are held constant from latch until the next accept. core_start is never asserted outside ISSUE.
- core_done in WAIT and in the same cycle as ISSUE: ISSUE has priority, and that done sets spurious_done. core_done in IDLE or RESP: ignored for data, sets spurious_done.
- rsp_ready on a non-owner bit, or while not in RESP, is ignored.
- Requests arriving while busy wait; req_valid may drop before acceptance without effect.

Optional Feature:
Macro CORDIC_ARB_TIMEOUT_EN.
- With the macro: a counter clears on ISSUE and increments in WAIT. When it reaches TIMEOUT_CYCLES-1 without core_done, the block goes to RESP with rsp_out1=rsp_out2=0 and rsp_err=1. rsp_err clears on the next accept.
- A core_done arriving after the timeout sets spurious_done.
- Without the macro: no counter, rsp_err tied 0, and WAIT waits indefinitely.

Test Plan:
- Single job: req0 mode=0, rot=1, shift=11, A=0x04DB, B=0x0000. Engine model done 12 cycles after start with out1=0x0400, out2=0x0200 -> exactly one core_start one cycle after accept; rsp_valid[0] with out1=0x0400, out2=0x0200; req1 never ready.
- Contention: both valid from reset -> grants 0,1,0,1 across four back-to-back jobs. core_a matches the granted requester's A (0x1111 vs 0x2222) on each start.
- Response backpressure: hold rsp_ready[0]=0 for 10 cycles -> rsp_valid[0] and results are stable. No new accept happens despite req1 valid; req1 is accepted the cycle after the handshake.
- Reset mid-WAIT: assert rst 3 cycles after start -> busy=0 and rsp_valid=0 next cycle. A late core_done sets spurious_done=1; the next job completes normally.
- Spurious done in IDLE: pulse core_done with core_out1=0xBEEF -> spurious_done=1, rsp_valid stays 0, rsp_out1 unchanged.
- With CORDIC_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=64, engine never done -> rsp_valid 64 cycles after start with rsp_err=1 and outputs 0. Without the macro -> still busy after 1000 cycles.

Source files
------------

// File: rtl/cordic_job_arbiter.sv
// Round-robin arbiter that shares one iterative CORDIC engine between two job requesters.
// Optional WAIT watchdog that returns an error response: define CORDIC_ARB_TIMEOUT_EN.
module cordic_job_arbiter #(
    parameter int unsigned FIXED_WIDTH    = 16,
    parameter int unsigned SHIFT_W        = 5,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               req_valid,
    output logic [1:0]               req_ready,
    input  logic [3:0]               req_mode,
    input  logic [1:0]               req_is_rotating,
    input  logic [2*SHIFT_W-1:0]     req_shift,
    input  logic [2*FIXED_WIDTH-1:0] req_a,
    input  logic [2*FIXED_WIDTH-1:0] req_b,
    output logic [1:0]               rsp_valid,
    input  logic [1:0]               rsp_ready,
    output logic [FIXED_WIDTH-1:0]   rsp_out1,
    output logic [FIXED_WIDTH-1:0]   rsp_out2,
    output logic                     rsp_err,
    output logic                     core_start,
    output logic [1:0]               core_mode,
    output logic                     core_is_rotating,
    output logic [SHIFT_W-1:0]       core_shift,
    output logic [FIXED_WIDTH-1:0]   core_a,
    output logic [FIXED_WIDTH-1:0]   core_b,
    input  logic [FIXED_WIDTH-1:0]   core_out1,
    input  logic [FIXED_WIDTH-1:0]   core_out2,
    input  logic                     core_done,
    output logic                     busy,
    output logic                     spurious_done
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e                 state_q, state_d;
    logic                   owner_q, owner_d;
    logic                   last_grant_q, last_grant_d;
    logic [1:0]             mode_q, mode_d;
    logic                   rot_q, rot_d;
    logic [SHIFT_W-1:0]     shift_q, shift_d;
    logic [FIXED_WIDTH-1:0] a_q, a_d;
    logic [FIXED_WIDTH-1:0] b_q, b_d;
    logic                   start_q, start_d;
    logic [1:0]             rsp_valid_q, rsp_valid_d;
    logic [FIXED_WIDTH-1:0] out1_q, out1_d;
    logic [FIXED_WIDTH-1:0] out2_q, out2_d;
    logic                   spurious_q, spurious_d;
    logic                   busy_q, busy_d;

    logic                   grant_c;
    logic                   grant_vld_c;
    logic                   accept_c;
    logic [1:0]             owner_oh_c;

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;
`endif

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    // Round-robin choice: a lone requester wins, on contention the one not granted last.
    always_comb begin
        grant_c     = 1'b0;
        grant_vld_c = 1'b0;
        unique case (req_valid)
            2'b01:   begin grant_vld_c = 1'b1; grant_c = 1'b0;          end
            2'b10:   begin grant_vld_c = 1'b1; grant_c = 1'b1;          end
            2'b11:   begin grant_vld_c = 1'b1; grant_c = ~last_grant_q; end
            default: ;
        endcase
    end

    assign req_ready  = (!rst && state_q == S_IDLE && grant_vld_c) ? {grant_c, ~grant_c} : 2'b00;
    assign accept_c   = |req_ready;
    assign owner_oh_c = {owner_q, ~owner_q};

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        mode_d       = mode_q;
        rot_d        = rot_q;
        shift_d      = shift_q;
        a_d          = a_q;
        b_d          = b_q;
        start_d      = 1'b0;
        rsp_valid_d  = rsp_valid_q;
        out1_d       = out1_q;
        out2_d       = out2_q;
        spurious_d   = spurious_q | (core_done && state_q != S_WAIT);
`ifdef CORDIC_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = err_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    state_d      = S_ISSUE;
                    owner_d      = grant_c;
                    last_grant_d = grant_c;
                    mode_d       = grant_c ? req_mode[3:2] : req_mode[1:0];
                    rot_d        = grant_c ? req_is_rotating[1] : req_is_rotating[0];
                    shift_d      = grant_c ? req_shift[2*SHIFT_W-1:SHIFT_W] : req_shift[SHIFT_W-1:0];
                    a_d          = grant_c ? req_a[2*FIXED_WIDTH-1:FIXED_WIDTH] : req_a[FIXED_WIDTH-1:0];
                    b_d          = grant_c ? req_b[2*FIXED_WIDTH-1:FIXED_WIDTH] : req_b[FIXED_WIDTH-1:0];
                    start_d      = 1'b1;
`ifdef CORDIC_ARB_TIMEOUT_EN
                    err_d        = 1'b0;
`endif
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef CORDIC_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (core_done) begin
                    state_d     = S_RESP;
                    out1_d      = core_out1;
                    out2_d      = core_out2;
                    rsp_valid_d = owner_oh_c;
                end
`ifdef CORDIC_ARB_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d     = S_RESP;
                        out1_d      = '0;
                        out2_d      = '0;
                        err_d       = 1'b1;
                        rsp_valid_d = owner_oh_c;
                    end
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready[owner_q]) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 2'b00;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            mode_q       <= '0;
            rot_q        <= 1'b0;
            shift_q      <= '0;
            a_q          <= '0;
            b_q          <= '0;
            start_q      <= 1'b0;
            rsp_valid_q  <= 2'b00;
            out1_q       <= '0;
            out2_q       <= '0;
            spurious_q   <= 1'b0;
            busy_q       <= 1'b0;
`ifdef CORDIC_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            mode_q       <= mode_d;
            rot_q        <= rot_d;
            shift_q      <= shift_d;
            a_q          <= a_d;
            b_q          <= b_d;
            start_q      <= start_d;
            rsp_valid_q  <= rsp_valid_d;
            out1_q       <= out1_d;
            out2_q       <= out2_d;
            spurious_q   <= spurious_d;
            busy_q       <= busy_d;
`ifdef CORDIC_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    assign core_start       = start_q;
    assign core_mode        = mode_q;
    assign core_is_rotating = rot_q;
    assign core_shift       = shift_q;
    assign core_a           = a_q;
    assign core_b           = b_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_out1         = out1_q;
    assign rsp_out2         = out2_q;
    assign busy             = busy_q;
    assign spurious_done    = spurious_q;
`ifdef CORDIC_ARB_TIMEOUT_EN
    assign rsp_err          = err_q;
`else
    assign rsp_err          = 1'b0;
`endif

endmodule
